// File: rtl/time_set_controller.sv
// time_set_controller
// Mode sequencer for the clock's time-setting path: RUN -> SET_HRS -> SET_MIN,
// single-cycle increment pulses with hold-to-auto-repeat, blink mask for the
// field being edited, and the run gate for timekeeping.
// Optional feature macro: SET_TIMEOUT_EN (idle SET state returns to RUN after
// TIMEOUT_S seconds without a button edge).
module time_set_controller #(
    parameter int unsigned REPEAT_DELAY = 16384,
    parameter int unsigned REPEAT_RATE  = 4096,
    parameter int unsigned BLINK_HALF   = 8192,
    parameter int unsigned TIMEOUT_S    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_mode,
    input  logic       btn_adj,
    input  logic       sec_tick,
    output logic       inc_hrs,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       run,
    output logic [1:0] mode,
    output logic [3:0] blank
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HRS = 2'b01,
        ST_SET_MIN = 2'b10
    } state_e;

    // The hold counter reloads to DELAY-RATE after each repeat so that the
    // next repeat lands exactly REPEAT_RATE cycles later without a modulo.
    localparam logic [31:0] DELAY_C  = 32'(REPEAT_DELAY);
    localparam logic [31:0] RELOAD_C = 32'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [31:0] BHALF_C  = 32'(BLINK_HALF);
    localparam logic [31:0] BLAST_C  = 32'(2 * BLINK_HALF - 1);

    state_e      state_q, state_d;
    logic        btn_mode_q, btn_adj_q;
    logic [31:0] hold_q, hold_d;
    logic [31:0] blink_q, blink_d;
    logic        inc_hrs_q, inc_hrs_d;
    logic        inc_min_q, inc_min_d;
    logic        clr_sec_q, clr_sec_d;
    logic        run_q, run_d;
    logic [3:0]  blank_q, blank_d;

    logic        mode_edge, adj_edge;
    logic        in_set;
    logic        adj_fire;
    logic        timeout_hit;

`ifdef SET_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT_S);
    logic [3:0]  tmo_q, tmo_d;
`else
    // Without the timeout feature the second tick and TIMEOUT_S have no consumer.
    logic        unused_tmo;
    assign unused_tmo = sec_tick ^ (TIMEOUT_S != 0);
`endif

    assign mode_edge = btn_mode & ~btn_mode_q;
    assign adj_edge  = btn_adj & ~btn_adj_q;
    assign in_set    = (state_q == ST_SET_HRS) || (state_q == ST_SET_MIN);

    // Next-state, counter and output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        hold_d      = '0;
        blink_d     = '0;
        inc_hrs_d   = 1'b0;
        inc_min_d   = 1'b0;
        clr_sec_d   = 1'b0;
        adj_fire    = 1'b0;
        timeout_hit = 1'b0;
        blank_d     = 4'b0000;
`ifdef SET_TIMEOUT_EN
        tmo_d       = '0;
`endif

        // Hold counter: initial pulse on the edge, then repeats while held.
        if (ena && in_set && btn_adj) begin
            if (adj_edge) begin
                hold_d   = '0;
                adj_fire = 1'b1;
            end else if (hold_q + 32'd1 == DELAY_C) begin
                hold_d   = RELOAD_C;
                adj_fire = 1'b1;
            end else begin
                hold_d   = hold_q + 32'd1;
            end
        end

`ifdef SET_TIMEOUT_EN
        // Idle-seconds counter; any button edge restarts it and wins over a tick.
        if (ena && in_set) begin
            if (mode_edge || adj_edge) begin
                tmo_d = '0;
            end else if (sec_tick) begin
                if (tmo_q + 4'd1 == TIMEOUT_C) begin
                    timeout_hit = 1'b1;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end else begin
                tmo_d = tmo_q;
            end
        end
`endif

        // Mode transitions; a mode edge always beats an adjust pulse.
        if (!ena) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mode_edge) state_d = ST_SET_HRS;
                end
                ST_SET_HRS: begin
                    if (mode_edge) begin
                        state_d = ST_SET_MIN;
                    end else if (timeout_hit) begin
                        state_d   = ST_RUN;
                        clr_sec_d = 1'b1;
                    end else if (adj_fire) begin
                        inc_hrs_d = 1'b1;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_edge || timeout_hit) begin
                        state_d   = ST_RUN;
                        clr_sec_d = 1'b1;
                    end else if (adj_fire) begin
                        inc_min_d = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        // Blink phase restarts whenever a SET state is freshly entered.
        if (state_d == ST_SET_HRS || state_d == ST_SET_MIN) begin
            if (state_d != state_q || blink_q == BLAST_C) begin
                blink_d = '0;
            end else begin
                blink_d = blink_q + 32'd1;
            end
        end

        if (!btn_adj && blink_d >= BHALF_C) begin
            if (state_d == ST_SET_HRS) blank_d = 4'b1100;
            else if (state_d == ST_SET_MIN) blank_d = 4'b0011;
        end

        run_d = (state_d == ST_RUN);
    end

    // State, counters, edge registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            btn_mode_q <= 1'b0;
            btn_adj_q  <= 1'b0;
            hold_q     <= '0;
            blink_q    <= '0;
            inc_hrs_q  <= 1'b0;
            inc_min_q  <= 1'b0;
            clr_sec_q  <= 1'b0;
            run_q      <= 1'b1;
            blank_q    <= 4'b0000;
`ifdef SET_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            btn_mode_q <= btn_mode;
            btn_adj_q  <= btn_adj;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            inc_hrs_q  <= inc_hrs_d;
            inc_min_q  <= inc_min_d;
            clr_sec_q  <= clr_sec_d;
            run_q      <= run_d;
            blank_q    <= blank_d;
`ifdef SET_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign inc_hrs = inc_hrs_q;
    assign inc_min = inc_min_q;
    assign clr_sec = clr_sec_q;
    assign run     = run_q;
    assign mode    = state_q;
    assign blank   = blank_q;

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencer for the multiplexed clock's time-setting datapath. It turns the two debounced button levels into a mode state machine (RUN, SET_HRS, SET_MIN) and emits single-cycle increment pulses to the hour and minute counters, with hold-to-auto-repeat. It also produces a per-digit blank mask so the field being edited blinks on the 7-segment multiplexer, and it gates timekeeping while setting. It sits between the button debouncers and the time-counter/digit-mux logic in the top level.

## Interface

Parameters:
- `REPEAT_DELAY`, default 16384: cycles a held adjust button must stay high before auto-repeat starts (0.5 s at 32768 Hz).
- `REPEAT_RATE`, default 4096: cycles between auto-repeat pulses (8 per second).
- `BLINK_HALF`, default 8192: cycles per blink half-period.
- `TIMEOUT_S`, default 10: `sec_tick` pulses without a button edge before a SET state returns to RUN.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: design enable; low forces RUN and suppresses all pulses.
- `btn_mode` input 1: debounced mode button, active-high level, synchronous to `clk`.
- `btn_adj` input 1: debounced adjust button, active-high level, synchronous to `clk`.
- `sec_tick` input 1: one-cycle pulse per second from the timebase.
- `inc_hrs` output 1: one-cycle pulse that increments the hours counter.
- `inc_min` output 1: one-cycle pulse that increments the minutes counter.
- `clr_sec` output 1: one-cycle pulse that zeroes the seconds counter and the quarter-minute LEDs.
- `run` output 1: high only in RUN; timekeeping advances only while high.
- `mode` output 2: state encoding, RUN=00, SET_HRS=01, SET_MIN=10. Code 11 is unused and recovers to RUN on the next edge.
- `blank` output 4: digit blank mask. Bit 0 = min_u, 1 = min_d, 2 = hrs_u, 3 = hrs_d. A 1 blanks the digit.

## Operation

- **Reset:** while `rst_n` is low, all outputs take their reset values: mode=RUN, `run`=1, `inc_hrs`=`inc_min`=`clr_sec`=0, `blank`=0000. Every counter is cleared and the edge registers are cleared to 0.
- **Edge detect:** one register per button. A rising edge is `btn & ~btn_q`.
- **RUN:**
  - A `btn_mode` edge moves to SET_HRS.
  - `btn_adj` is ignored; no increment pulses are produced.
- **SET_HRS:**
  - A `btn_mode` edge moves to SET_MIN.
  - A `btn_adj` edge pulses `inc_hrs`.
- **SET_MIN:**
  - A `btn_mode` edge moves to RUN and pulses `clr_sec` on that same edge.
  - A `btn_adj` edge pulses `inc_min`.
- **Auto-repeat:**
  - A 32-bit hold counter clears on the adjust edge and counts every cycle while `btn_adj` stays high.
  - First repeat pulse: `REPEAT_DELAY` cycles after the initial pulse.
  - Further repeat pulses: every `REPEAT_RATE` cycles after that.
  - Releasing the button stops repeating immediately.
  - Leaving the SET state stops repeating immediately.
- **Blink:**
  - The blink counter restarts on entry to each SET state.
  - The first `BLINK_HALF` cycles are the visible phase; the next `BLINK_HALF` cycles are the blanked phase.
  - In the blanked phase, SET_HRS blanks 1100 and SET_MIN blanks 0011.
  - While `btn_adj` is high, `blank`=0000 so the digits are readable during repeat.
  - In RUN, `blank`=0000.
- **Simultaneous events:**
  - A mode edge and an adjust edge on the same cycle: the mode edge wins and no increment is issued.
  - A `sec_tick` on the same cycle as a button edge: the timeout counter clears; the button edge wins.
- **`ena` low:** forces RUN combinationally on the next edge, with no `clr_sec`. All counters clear.
- **Increment wrap:** wrap-around of hours (23→00) and minutes (59→00) is the counters' job; this block only pulses.

## Timing

- All outputs are registered.
- An input edge sampled at clock edge N produces its pulse or state change on edge N, visible for the cycle after N.
- `mode`, `run` and `blank` update on that same edge N.
- Every pulse is exactly 1 cycle wide. Pulses never overlap: at most one of `inc_hrs`/`inc_min` is asserted per cycle.
- Asserting `rst_n` low mid-repeat or mid-SET clears everything asynchronously. Release is synchronous to the next edge.

## Configuration

- `SET_TIMEOUT_EN` defined:
  - In SET_HRS and SET_MIN, a 4-bit counter counts `sec_tick` pulses and clears on any button edge.
  - When the count reaches `TIMEOUT_S`, the state goes to RUN with a `clr_sec` pulse on that edge.
- `SET_TIMEOUT_EN` undefined:
  - No timeout counter is built; SET states persist indefinitely.
  - `TIMEOUT_S` is unused.

## Test plan

Bench parameters: `REPEAT_DELAY`=8, `REPEAT_RATE`=4, `BLINK_HALF`=5, `TIMEOUT_S`=3.

- **Reset:** `rst_n` low mid-cycle -> immediately mode=00, `run`=1, `blank`=0000, all pulses 0.
- **Mode cycle:** three `btn_mode` presses -> mode 00→01→10→00. `clr_sec` is high for exactly 1 cycle on the third press; `run`=0 while in 01 and 10.
- **Auto-repeat:** in SET_HRS, hold `btn_adj` 20 cycles -> `inc_hrs` pulses at relative cycles 0, 8, 12, 16 (4 total). `inc_min` stays 0 and `blank`=0000 throughout the hold.
- **Blink:** in SET_MIN with no buttons pressed -> `blank` shows 0000 for 5 cycles, then 0011 for 5 cycles, repeating.
- **Simultaneous edges:** `btn_mode` and `btn_adj` rise on the same cycle in SET_HRS -> mode=10 and no `inc_hrs`. In RUN, a `btn_adj` press produces no pulse.
- **Timeout (`SET_TIMEOUT_EN` defined):** enter SET_HRS and apply 3 `sec_tick` pulses -> mode=00 and `clr_sec` pulses once. A `btn_adj` press after the 2nd tick delays the return until 3 further ticks.
